// File: rtl/imem_program_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_program_loader_if
// Brief    : Byte-stream and instruction-memory write bundle of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_program_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [7:0]        words_loaded;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, words_loaded
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Brief    : Assembles a big-endian byte stream into 32-bit words and writes
//            them to instruction memory while holding the processor.
// Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  wire logic                  orig_clk,
    input  wire logic                  rst_n,
    imem_program_loader_if.slave       bus
);
    localparam logic [ADDR_W-1:0] c_BASE_ADDR = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_COLLECT = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_count, w_count_nxt;
    logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]        r_word_idx, w_word_idx_nxt;
    logic [23:0]       r_shift, w_shift_nxt;
    logic [ADDR_W-1:0] r_imem_addr, w_imem_addr_nxt;
    logic [31:0]       r_imem_wdata, w_imem_wdata_nxt;
    logic [7:0]        r_words_loaded, w_words_loaded_nxt;
    logic              r_in_ready;
    logic              r_imem_we;
    logic              r_cpu_hold;
    logic              r_done;
    logic              w_accept;

    assign w_accept = bus.in_valid & r_in_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_count_nxt        = r_count;
        w_byte_cnt_nxt     = r_byte_cnt;
        w_word_idx_nxt     = r_word_idx;
        w_shift_nxt        = r_shift;
        w_imem_addr_nxt    = r_imem_addr;
        w_imem_wdata_nxt   = r_imem_wdata;
        w_words_loaded_nxt = r_words_loaded;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt        = S_LEN;
                    w_words_loaded_nxt = 8'd0;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    if (bus.in_data == 8'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_count_nxt    = bus.in_data;
                        w_byte_cnt_nxt = 2'd0;
                        w_word_idx_nxt = 8'd0;
                        w_state_nxt    = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_shift_nxt    = {r_shift[15:0], bus.in_data};
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    // Fourth byte: the completed word goes straight to the write port
                    if (r_byte_cnt == 2'd3) begin
                        w_imem_addr_nxt  = c_BASE_ADDR + ADDR_W'(r_word_idx);
                        w_imem_wdata_nxt = {r_shift, bus.in_data};
                        w_state_nxt      = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_words_loaded_nxt = r_words_loaded + 8'd1;
                w_word_idx_nxt     = r_word_idx + 8'd1;
                w_state_nxt        = ((r_word_idx + 8'd1) == r_count) ? S_DONE : S_COLLECT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and status flags are decoded from the next state so they are registered
    always_ff @(posedge orig_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_count        <= 8'd0;
            r_byte_cnt     <= 2'd0;
            r_word_idx     <= 8'd0;
            r_shift        <= 24'd0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= 32'd0;
            r_words_loaded <= 8'd0;
            r_in_ready     <= 1'b0;
            r_imem_we      <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
            r_word_idx     <= w_word_idx_nxt;
            r_shift        <= w_shift_nxt;
            r_imem_addr    <= w_imem_addr_nxt;
            r_imem_wdata   <= w_imem_wdata_nxt;
            r_words_loaded <= w_words_loaded_nxt;
            r_in_ready     <= (w_state_nxt == S_LEN) || (w_state_nxt == S_COLLECT);
            r_imem_we      <= (w_state_nxt == S_WRITE);
            r_cpu_hold     <= (w_state_nxt != S_DONE);
            r_done         <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_imem_wdata;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.done         = r_done;
    assign bus.words_loaded = r_words_loaded;
endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_program_loader
// Brief    : Self-checking bench; two loaders (base 00 and FE) share one stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;
    logic       orig_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'd0;

    int tests = 0;
    int fails = 0;
    int ready_viol = 0;

    logic [7:0]  stream[$];
    logic [39:0] wq0[$];
    logic [39:0] wq1[$];

    always #5 orig_clk = ~orig_clk;

    imem_program_loader_if #(.ADDR_W(8)) if0 ();
    imem_program_loader_if #(.ADDR_W(8)) if1 ();

    assign if0.start    = start;
    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.start    = start;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;

    imem_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .orig_clk (orig_clk),
        .rst_n    (rst_n),
        .bus      (if0)
    );

    imem_program_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
        .orig_clk (orig_clk),
        .rst_n    (rst_n),
        .bus      (if1)
    );

    // Record every write strobe seen mid-cycle
    always @(negedge orig_clk) begin
        if (if0.imem_we === 1'b1) wq0.push_back({if0.imem_addr, if0.imem_wdata});
        if (if1.imem_we === 1'b1) wq1.push_back({if1.imem_addr, if1.imem_wdata});
        if ((if0.imem_we === 1'b1 && if0.in_ready !== 1'b0) ||
            (if1.imem_we === 1'b1 && if1.in_ready !== 1'b0)) ready_viol++;
    end

    // Reference: word i is bytes 1+4i..4+4i big-endian, at base+i modulo 256
    function automatic logic [39:0] model_entry(input int i, input logic [7:0] base);
        logic [7:0] a;
        a = base + i[7:0];
        return {a, stream[1+4*i], stream[2+4*i], stream[3+4*i], stream[4+4*i]};
    endfunction

    task automatic make_stream(input int n);
        stream.delete();
        stream.push_back(n[7:0]);
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge orig_clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            @(negedge orig_clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (if0.in_ready === 1'b1) begin
                @(negedge orig_clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge orig_clk);
        end
        tests++;
        fails++;
        $display("FAIL send_byte_timeout: in_ready=%b, required 1 within 50 cycles", if0.in_ready);
        in_valid = 1'b0;
    endtask

    task automatic stream_all(input int mode);
        for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2)));
    endtask

    task automatic wait_done();
        for (int t = 0; t < 50; t++) begin
            if (if0.done === 1'b1) return;
            @(negedge orig_clk);
        end
        tests++;
        fails++;
        $display("FAIL wait_done_timeout: done=%b, required 1 within 50 cycles", if0.done);
    endtask

    task automatic test_reset();
        start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge orig_clk);
        tests++;
        if ({if0.in_ready, if0.imem_we, if0.cpu_hold, if0.done, if0.words_loaded, if0.imem_addr, if0.imem_wdata}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_state0: rdy/we/hold/done=%b%b%b%b wl=%h addr=%h data=%h, required 0010 00 00 00000000",
                     if0.in_ready, if0.imem_we, if0.cpu_hold, if0.done, if0.words_loaded, if0.imem_addr, if0.imem_wdata);
        end
        tests++;
        if ({if1.in_ready, if1.imem_we, if1.cpu_hold, if1.done, if1.words_loaded, if1.imem_addr, if1.imem_wdata}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_state1: rdy/we/hold/done=%b%b%b%b wl=%h addr=%h data=%h, required 0010 00 00 00000000",
                     if1.in_ready, if1.imem_we, if1.cpu_hold, if1.done, if1.words_loaded, if1.imem_addr, if1.imem_wdata);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge orig_clk);
        tests++;
        if (if0.in_ready !== 1'b0 || if0.cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL start_in_reset_ignored: in_ready=%b cpu_hold=%b, required 0 1", if0.in_ready, if0.cpu_hold);
        end
    endtask

    task automatic test_zero_len();
        wq0.delete();
        wq1.delete();
        pulse_start();
        tests++;
        if (if0.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL len_ready: in_ready=%b, required 1", if0.in_ready);
        end
        send_byte(8'h00, 0);
        tests++;
        if ({if0.done, if0.cpu_hold, if0.words_loaded, if0.in_ready} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL zero_len_done: done=%b hold=%b wl=%0d rdy=%b, required 1 0 0 0",
                     if0.done, if0.cpu_hold, if0.words_loaded, if0.in_ready);
        end
        #1;
        tests++;
        if (wq0.size() + wq1.size() != 0) begin
            fails++;
            $display("FAIL zero_len_no_write: writes=%0d, required 0", wq0.size() + wq1.size());
        end
        @(negedge orig_clk);
    endtask

    task automatic test_async_reset();
        @(posedge orig_clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({if0.cpu_hold, if0.done, if0.imem_we, if0.in_ready, if1.cpu_hold, if1.done}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: hold/done/we/rdy=%b%b%b%b dut1 hold/done=%b%b, required 1000 10",
                     if0.cpu_hold, if0.done, if0.imem_we, if0.in_ready, if1.cpu_hold, if1.done);
        end
        @(negedge orig_clk);
        rst_n = 1'b1;
        @(negedge orig_clk);
    endtask

    task automatic test_basic();
        stream = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        wq0.delete();
        wq1.delete();
        ready_viol = 0;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            send_byte(stream[i], 0);
            if (i == 4 || i == 8) begin
                tests++;
                if (if0.imem_we !== 1'b1 || {if0.imem_addr, if0.imem_wdata} !== model_entry(i / 4 - 1, 8'h00)) begin
                    fails++;
                    $display("FAIL basic_latency_w%0d: we=%b addr/data=%h, required 1 %h",
                             i / 4 - 1, if0.imem_we, {if0.imem_addr, if0.imem_wdata}, model_entry(i / 4 - 1, 8'h00));
                end
            end
        end
        @(negedge orig_clk);
        tests++;
        if ({if0.done, if0.cpu_hold, if0.words_loaded, if1.words_loaded} !== {1'b1, 1'b0, 8'd2, 8'd2}) begin
            fails++;
            $display("FAIL basic_done: done=%b hold=%b wl=%0d/%0d, required 1 0 2/2",
                     if0.done, if0.cpu_hold, if0.words_loaded, if1.words_loaded);
        end
        #1;
        tests++;
        if (wq0.size() != 2 || wq1.size() != 2 || ready_viol != 0) begin
            fails++;
            $display("FAIL basic_writes: count=%0d/%0d ready_during_we=%0d, required 2/2 0",
                     wq0.size(), wq1.size(), ready_viol);
        end
        for (int i = 0; i < wq0.size() && i < 2; i++) begin
            tests++;
            if (wq0[i] !== model_entry(i, 8'h00) || wq1[i] !== model_entry(i, 8'hFE)) begin
                fails++;
                $display("FAIL basic_word%0d: got %h/%h, required %h/%h",
                         i, wq0[i], wq1[i], model_entry(i, 8'h00), model_entry(i, 8'hFE));
            end
        end
        @(negedge orig_clk);
    endtask

    task automatic test_wrap_gaps();
        make_stream(3);
        wq0.delete();
        wq1.delete();
        ready_viol = 0;
        pulse_start();
        stream_all(1);
        wait_done();
        #1;
        tests++;
        if (wq1.size() != 3 || wq0.size() != 3 || ready_viol != 0 || if1.words_loaded !== 8'd3) begin
            fails++;
            $display("FAIL wrap_count: writes=%0d/%0d ready_during_we=%0d wl=%0d, required 3/3 0 3",
                     wq0.size(), wq1.size(), ready_viol, if1.words_loaded);
        end
        for (int i = 0; i < wq1.size() && i < 3; i++) begin
            tests++;
            if (wq1[i] !== model_entry(i, 8'hFE) || wq0[i] !== model_entry(i, 8'h00)) begin
                fails++;
                $display("FAIL wrap_word%0d: got %h/%h, required %h/%h",
                         i, wq0[i], wq1[i], model_entry(i, 8'h00), model_entry(i, 8'hFE));
            end
        end
        @(negedge orig_clk);
    endtask

    task automatic test_reset_mid_load();
        make_stream(2);
        wq0.delete();
        wq1.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i], 0);
        rst_n = 1'b0;
        repeat (2) @(negedge orig_clk);
        tests++;
        if ({if0.cpu_hold, if0.done, if0.in_ready, if0.imem_we} !== 4'b1000) begin
            fails++;
            $display("FAIL midload_reset_state: hold/done/rdy/we=%b%b%b%b, required 1000",
                     if0.cpu_hold, if0.done, if0.in_ready, if0.imem_we);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge orig_clk);
        #1;
        tests++;
        if (wq0.size() != 1 || wq1.size() != 1 || wq0[0] !== model_entry(0, 8'h00) || wq1[0] !== model_entry(0, 8'hFE)) begin
            fails++;
            $display("FAIL midload_partial: writes=%0d/%0d first=%h, required 1/1 %h",
                     wq0.size(), wq1.size(), wq0[0], model_entry(0, 8'h00));
        end
        @(negedge orig_clk);
        make_stream(2);
        wq0.delete();
        wq1.delete();
        pulse_start();
        stream_all(2);
        wait_done();
        #1;
        tests++;
        if (wq0.size() != 2 || wq1.size() != 2 || if0.words_loaded !== 8'd2) begin
            fails++;
            $display("FAIL reload_count: writes=%0d/%0d wl=%0d, required 2/2 2", wq0.size(), wq1.size(), if0.words_loaded);
        end
        for (int i = 0; i < wq0.size() && i < 2; i++) begin
            tests++;
            if (wq0[i] !== model_entry(i, 8'h00) || wq1[i] !== model_entry(i, 8'hFE)) begin
                fails++;
                $display("FAIL reload_word%0d: got %h/%h, required %h/%h",
                         i, wq0[i], wq1[i], model_entry(i, 8'h00), model_entry(i, 8'hFE));
            end
        end
        @(negedge orig_clk);
    endtask

    task automatic test_start_ignored();
        make_stream(3);
        wq0.delete();
        wq1.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
        start = 1'b1;
        send_byte(stream[3], 0);
        start = 1'b0;
        for (int i = 4; i < stream.size(); i++) send_byte(stream[i], 0);
        wait_done();
        #1;
        tests++;
        if (wq0.size() != 3 || if0.words_loaded !== 8'd3 || if0.cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL start_collect_count: writes=%0d wl=%0d hold=%b, required 3 3 0",
                     wq0.size(), if0.words_loaded, if0.cpu_hold);
        end
        for (int i = 0; i < wq0.size() && i < 3; i++) begin
            tests++;
            if (wq0[i] !== model_entry(i, 8'h00)) begin
                fails++;
                $display("FAIL start_collect_word%0d: got %h, required %h", i, wq0[i], model_entry(i, 8'h00));
            end
        end
        @(negedge orig_clk);
        pulse_start();
        tests++;
        if ({if0.cpu_hold, if0.done, if0.words_loaded, if0.in_ready, if1.cpu_hold, if1.done}
            !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL restart_from_done: hold=%b done=%b wl=%0d rdy=%b dut1 %b%b, required 1 0 0 1 10",
                     if0.cpu_hold, if0.done, if0.words_loaded, if0.in_ready, if1.cpu_hold, if1.done);
        end
        make_stream(1);
        wq0.delete();
        wq1.delete();
        stream_all(0);
        wait_done();
        #1;
        tests++;
        if (wq0.size() != 1 || wq0[0] !== model_entry(0, 8'h00) || wq1[0] !== model_entry(0, 8'hFE)) begin
            fails++;
            $display("FAIL restart_load: writes=%0d first=%h, required 1 %h", wq0.size(), wq0[0], model_entry(0, 8'h00));
        end
        @(negedge orig_clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            make_stream(n);
            wq0.delete();
            wq1.delete();
            ready_viol = 0;
            pulse_start();
            stream_all(2);
            wait_done();
            #1;
            tests++;
            if (wq0.size() != n || wq1.size() != n || if0.words_loaded !== 8'(n) || ready_viol != 0) begin
                fails++;
                $display("FAIL random%0d_count: writes=%0d/%0d wl=%0d ready_during_we=%0d, required %0d/%0d %0d 0",
                         k, wq0.size(), wq1.size(), if0.words_loaded, ready_viol, n, n, n);
            end
            for (int i = 0; i < wq0.size() && i < wq1.size() && i < n; i++) begin
                tests++;
                if (wq0[i] !== model_entry(i, 8'h00) || wq1[i] !== model_entry(i, 8'hFE)) begin
                    fails++;
                    $display("FAIL random%0d_word%0d: got %h/%h, required %h/%h",
                             k, i, wq0[i], wq1[i], model_entry(i, 8'h00), model_entry(i, 8'hFE));
                end
            end
            @(negedge orig_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge orig_clk);
        test_reset();
        test_zero_len();
        test_async_reset();
        test_basic();
        test_wrap_gaps();
        test_reset_mid_load();
        test_start_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
